// File: rtl/dcache_pkg.sv
// ============================================================================
// Module : dcache_pkg
// Brief  : Shared types, default geometry and width helpers for the data cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int DEF_LOG_NUM_BYTES_PER_LINE = 5;
    localparam int DEF_LOG_NUM_LINES          = 9;
    localparam int ADDR_W                     = 32;
    localparam int DATA_W                     = 32;

    function automatic int tag_width(input int log_bytes, input int log_lines);
        return ADDR_W - log_lines - log_bytes;
    endfunction

    function automatic int word_off_width(input int log_bytes);
        return log_bytes - 2;
    endfunction

    localparam int TAG_W          = tag_width(DEF_LOG_NUM_BYTES_PER_LINE, DEF_LOG_NUM_LINES);
    localparam int INDEX_W        = DEF_LOG_NUM_LINES;
    localparam int WORD_OFF_W     = word_off_width(DEF_LOG_NUM_BYTES_PER_LINE);
    localparam int WORDS_PER_LINE = 1 << WORD_OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_REFILL    = 2'd2,
        ST_WRITE_MEM = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_if.sv
// ============================================================================
// Module : dcache_if
// Brief  : CPU-side and memory-side request/acknowledge bundle of the cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dcache_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // The cache is the slave of the CPU and the master of memory
    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ack, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dcache_data_ram.sv
// ============================================================================
// Module : dcache_data_ram
// Brief  : Word-wide data store, one registered read port and one write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_data_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Write-first: a read issued alongside the final refill beat sees that beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module : dcache_ctrl
// Brief  : Direct-mapped write-through, no-write-allocate data cache controller.
//          Define DCACHE_STATS_EN to add hit_count / miss_count outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LOG_NUM_BYTES_PER_LINE = DEF_LOG_NUM_BYTES_PER_LINE,
    parameter int LOG_NUM_LINES          = DEF_LOG_NUM_LINES
) (
    input  wire logic  clk,
    input  wire logic  rst,
    dcache_if.slave    bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int c_LB        = LOG_NUM_BYTES_PER_LINE;
    localparam int c_TAG_W     = tag_width(LOG_NUM_BYTES_PER_LINE, LOG_NUM_LINES);
    localparam int c_INDEX_W   = LOG_NUM_LINES;
    localparam int c_WOFF_W    = word_off_width(LOG_NUM_BYTES_PER_LINE);
    localparam int c_NUM_LINES = 1 << LOG_NUM_LINES;
    localparam int c_RAM_AW    = c_INDEX_W + c_WOFF_W;
    localparam logic [c_WOFF_W-1:0] c_LAST_WORD = '1;

    state_t                r_state;
    logic [31:0]           r_addr;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic                  r_hit;
    logic                  r_refilled;
    logic [c_WOFF_W-1:0]   r_cnt;
    logic [c_NUM_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0]    r_tag [c_NUM_LINES];

    logic                  r_cpu_ack;
    logic [31:0]           r_cpu_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]           r_hit_count;
    logic [31:0]           r_miss_count;
`endif

    logic [c_INDEX_W-1:0]  w_index;
    logic [c_TAG_W-1:0]    w_tag;
    logic [c_WOFF_W-1:0]   w_woff;
    logic [c_WOFF_W-1:0]   w_cnt_nxt;
    logic                  w_hit;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_ram_re;
    logic [c_RAM_AW-1:0]   w_ram_raddr;
    logic                  w_ram_we;
    logic [c_RAM_AW-1:0]   w_ram_waddr;
    logic [31:0]           w_ram_wdata;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused;

    assign w_index     = r_addr[c_LB +: c_INDEX_W];
    assign w_tag       = r_addr[31 -: c_TAG_W];
    assign w_woff      = r_addr[2 +: c_WOFF_W];
    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // The cycle carrying cpu_ack is never treated as a new request
    assign w_accept    = (r_state == ST_IDLE) && bus.cpu_req && !r_cpu_ack;
    assign w_last_beat = (r_state == ST_REFILL) && bus.mem_ack && (r_cnt == c_LAST_WORD);
    assign w_unused    = ^bus.cpu_addr[1:0];

    // Read on request acceptance, and again as the refilled line becomes valid
    assign w_ram_re    = w_accept || w_last_beat;
    assign w_ram_raddr = w_accept ? {bus.cpu_addr[c_LB +: c_INDEX_W], bus.cpu_addr[2 +: c_WOFF_W]}
                                  : {w_index, w_woff};
    assign w_ram_we    = !rst && bus.mem_ack &&
                         ((r_state == ST_REFILL) || ((r_state == ST_WRITE_MEM) && r_hit));
    assign w_ram_waddr = (r_state == ST_REFILL) ? {w_index, r_cnt} : {w_index, w_woff};
    assign w_ram_wdata = (r_state == ST_REFILL) ? bus.mem_rdata : r_wdata;

    dcache_data_ram #(
        .ADDR_W (c_RAM_AW),
        .DATA_W (32)
    ) u_data_ram (
        .clk     (clk),
        .rst     (rst),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata)
    );

    always_ff @(posedge clk) begin
        if (w_last_beat && !rst) begin
            r_tag[w_index] <= w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_hit        <= 1'b0;
            r_refilled   <= 1'b0;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
`ifdef DCACHE_STATS_EN
            r_hit_count  <= '0;
            r_miss_count <= '0;
`endif
        end else begin
            r_cpu_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= {bus.cpu_addr[31:2], 2'b00};
                        r_we    <= bus.cpu_we;
                        r_wdata <= bus.cpu_wdata;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_refilled <= 1'b0;
                    if (r_we) begin
                        r_hit       <= w_hit;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_state     <= ST_WRITE_MEM;
                    end else begin
`ifdef DCACHE_STATS_EN
                        if (!r_refilled) begin
                            if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
                            else       r_miss_count <= r_miss_count + 32'd1;
                        end
`endif
                        if (w_hit) begin
                            r_cpu_ack   <= 1'b1;
                            r_cpu_rdata <= w_ram_rdata;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt      <= '0;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {r_addr[31:c_LB], {c_LB{1'b0}}};
                            r_state    <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (bus.mem_ack) begin
                        if (r_cnt == c_LAST_WORD) begin
                            r_mem_req          <= 1'b0;
                            r_valid[w_index]   <= 1'b1;
                            r_refilled         <= 1'b1;
                            r_cnt              <= '0;
                            r_state            <= ST_LOOKUP;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_mem_addr <= {r_addr[31:c_LB], w_cnt_nxt, 2'b00};
                        end
                    end
                end
                ST_WRITE_MEM: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cpu_ack <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
`ifdef DCACHE_STATS_EN
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module : tb_dcache_ctrl
// Brief  : Directed plus randomized checks of dcache_ctrl against a line-level
//          cache model and a word-addressed backing memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } beat_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder state and its own backing store
    beat_t       beats[$];
    beat_t       nb;
    logic [31:0] rmem [logic [31:0]];
    int unsigned wait_cnt;
    int          beats_done;

    // Reference model: per-line valid/tag plus an independent backing store
    bit          m_valid [512];
    logic [17:0] m_tag   [512];
    logic [31:0] mmem    [logic [31:0]];
    int          m_hits;
    int          m_misses;

    function automatic logic [31:0] resp_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : a;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt      = 0;
        beats_done    = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                beats_done++;
            end else if (bus.mem_req && !rst) begin
                if (wait_cnt == 0) begin
                    nb.addr = bus.mem_addr;
                    nb.we   = bus.mem_we;
                    if (bus.mem_we) begin
                        nb.data = bus.mem_wdata;
                        rmem[bus.mem_addr] = bus.mem_wdata;
                    end else begin
                        nb.data = resp_rd(bus.mem_addr);
                        bus.mem_rdata = nb.data;
                    end
                    beats.push_back(nb);
                    bus.mem_ack = 1'b1;
                    wait_cnt = $urandom_range(0, 2);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic cpu_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wd);
        logic [31:0] a_w;
        int          idx;
        logic [17:0] tg;
        bit          exp_hit;
        int          cyc;
        bit          got;
        logic [31:0] rd;
        logic [31:0] base;
        a_w     = {addr[31:2], 2'b00};
        idx     = int'((addr >> 5) & 32'h1FF);
        tg      = addr[31:14];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        base    = {addr[31:5], 5'b0};
        cyc     = 0;
        got     = 1'b0;
        rd      = '0;
        beats.delete();
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = addr;
        bus.cpu_we    = we;
        bus.cpu_wdata = wd;
        while (!got && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.cpu_ack) begin
                got = 1'b1;
                rd  = bus.cpu_rdata;
            end
        end
        bus.cpu_req = 1'b0;
        check({tag, "_ack"}, 32'(got), 32'd1);
        if (!got) return;
        @(posedge clk); #1;
        check({tag, "_ack_single"}, 32'(bus.cpu_ack), 32'd0);
        if (we) begin
            check({tag, "_wbeats"}, beats.size(), 32'd1);
            if (beats.size() >= 1) begin
                check({tag, "_waddr"}, beats[0].addr, a_w);
                check({tag, "_wwe"},   32'(beats[0].we), 32'd1);
                check({tag, "_wdata"}, beats[0].data, wd);
            end
            mmem[a_w] = wd;
        end else begin
            check({tag, "_rbeats"}, beats.size(), exp_hit ? 32'd0 : 32'd8);
            if (!exp_hit) begin
                for (int i = 0; i < beats.size() && i < 8; i++) begin
                    check({tag, "_raddr"}, beats[i].addr, base + 32'(4 * i));
                    check({tag, "_rwe"},   32'(beats[i].we), 32'd0);
                end
                m_misses++;
            end else begin
                check({tag, "_hit_lat"}, cyc, 32'd2);
                m_hits++;
            end
            check({tag, "_rdata"}, rd, model_rd(a_w));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
`ifdef DCACHE_STATS_EN
        check({tag, "_hit_count"},  hit_count,  32'(m_hits));
        check({tag, "_miss_count"}, miss_count, 32'(m_misses));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          start;
        int          cyc;
        bit          saw_ack;
        bit          quiet;
        logic [31:0] a;
        logic [17:0] tsel [3];
        int          isel [3];

        rst           = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_cpu_ack",   32'(bus.cpu_ack), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata,    32'd0);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we),  32'd0);
        check("rst_mem_addr",  bus.mem_addr,     32'd0);
        check("rst_mem_wdata", bus.mem_wdata,    32'd0);
        @(posedge clk); #1;

        cpu_txn("miss_1004", 32'h0000_1004, 1'b0, '0);
        check("miss_1004_val", bus.cpu_rdata, 32'h0000_1004);
        cpu_txn("hit_1008", 32'h0000_1008, 1'b0, '0);
`ifdef DCACHE_STATS_EN
        check("stats_miss", miss_count, 32'd1);
        check("stats_hit",  hit_count,  32'd1);
`endif
        cpu_txn("wr_1008",    32'h0000_1008, 1'b1, 32'hDEAD_BEEF);
        cpu_txn("hit_wr1008", 32'h0000_1008, 1'b0, '0);
        cpu_txn("evict_401000", 32'h0040_1000, 1'b0, '0);
        cpu_txn("remiss_1000",  32'h0000_1000, 1'b0, '0);
        cpu_txn("wr_miss",      32'h0000_3004, 1'b1, 32'h1234_5678);
        cpu_txn("rd_after_wrmiss", 32'h0000_3004, 1'b0, '0);

        // Abort a refill with reset after its third beat
        beats.delete();
        start   = beats_done;
        cyc     = 0;
        saw_ack = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_2000;
        bus.cpu_we   = 1'b0;
        while ((beats_done - start) < 3 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.cpu_ack) saw_ack = 1'b1;
        end
        check("abort_reached3", 32'((beats_done - start) >= 3), 32'd1);
        rst         = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("abort_mem_req", 32'(bus.mem_req), 32'd0);
        check("abort_no_ack",  32'(bus.cpu_ack || saw_ack), 32'd0);
        quiet = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_req || bus.cpu_ack) quiet = 1'b0;
        end
        check("abort_quiet", 32'(quiet), 32'd1);
        cpu_txn("abort_reread", 32'h0000_2000, 1'b0, '0);

        tsel[0] = 18'h00000; tsel[1] = 18'h00001; tsel[2] = 18'h00100;
        isel[0] = 32'h80;    isel[1] = 32'h81;    isel[2] = 32'h100;
        for (int n = 0; n < 80; n++) begin
            a = {tsel[$urandom_range(0, 2)], 9'(isel[$urandom_range(0, 2)]),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            cpu_txn("rand", a, ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LOG_NUM_BYTES_PER_LINE, default 5, log2 bytes per line (8 words).
REQ-002 SHALL have parameter LOG_NUM_LINES, default 9, log2 line count (512 lines).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cpu_req, input, 1, CPU request valid; held with addr/we/wdata stable until cpu_ack.
REQ-006 SHALL have port cpu_addr, input, 32, byte address; bits [1:0] ignored.
REQ-007 SHALL have port cpu_we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port cpu_wdata, input, 32, write data.
REQ-009 SHALL have port cpu_rdata, output, 32, read data, valid only while cpu_ack=1.
REQ-010 SHALL have port cpu_ack, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports mem_req (out,1), mem_we (out,1), mem_addr (out,32), mem_wdata (out,32), mem_rdata (in,32), mem_ack (in,1): word-wide memory handshake; mem_req held with mem_* stable until mem_ack.

Function
REQ-012 SHALL implement a direct-mapped, write-through, no-write-allocate cache; tag = addr[31:LOG_NUM_LINES+LOG_NUM_BYTES_PER_LINE] (18 bits default), index = next LOG_NUM_LINES bits, word offset = addr[LOG_NUM_BYTES_PER_LINE-1:2].
REQ-013 SHALL use FSM states IDLE, LOOKUP, REFILL, WRITE_MEM.
REQ-014 IDLE: cpu_req=1 -> LOOKUP next cycle (data array read issued, registered).
REQ-015 LOOKUP, read hit (valid & tag match): cpu_ack=1 with cpu_rdata this cycle -> IDLE; read hit latency = 2 cycles from cpu_req rise to cpu_ack.
REQ-016 LOOKUP, read miss -> REFILL with word counter = 0.
REQ-017 REFILL: mem_req=1, mem_we=0, mem_addr = line base + 4*counter; each mem_ack writes mem_rdata into data word [counter], counter+1; on mem_ack of last word set valid, write tag -> LOOKUP (guaranteed hit).
REQ-018 LOOKUP, write (hit or miss) -> WRITE_MEM; WRITE_MEM: mem_req=1, mem_we=1, mem_addr = cpu_addr with [1:0]=0, mem_wdata = cpu_wdata; on mem_ack: if hit, update cached word; cpu_ack=1 -> IDLE; miss leaves valid/tag unchanged.
REQ-019 mem_req SHALL deassert in the cycle after mem_ack of the final beat; mem_ack outside REFILL/WRITE_MEM SHALL be ignored.
REQ-020 cpu_ack SHALL never assert in two consecutive cycles; new request accepted no earlier than the cycle after cpu_ack.
REQ-021 Refill replaces the resident line unconditionally (write-through, never dirty).

Reset
REQ-022 rst=1 SHALL clear all valid bits in one cycle, force IDLE, counter 0, cpu_ack=0, mem_req=0, mem_we=0, cpu_rdata=0, mem_addr=0, mem_wdata=0; tag/data contents need not be cleared.
REQ-023 rst mid-REFILL or mid-WRITE_MEM SHALL abort: mem_req low next cycle, partial line left invalid, no cpu_ack.

Configuration
REQ-024 With macro DCACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (32 bits each, cleared by rst, +1 per LOOKUP resolved as read hit / read miss, the post-refill LOOKUP not counted, wrap at 2^32); without it, ports and counters SHALL be absent.

Structure
REQ-025 Shared package dcache_pkg SHALL hold the FSM state enum, derived widths (TAG_W, INDEX_W, WORD_OFF_W) and WORDS_PER_LINE.
REQ-026 Data storage SHALL be sub-module dcache_data_ram (one read port, registered output, one write port, word granularity); valid/tag storage stays in dcache_ctrl.

Verification
REQ-027 After rst, read 0x0000_1004 with memory word = addr -> 8 REFILL beats at 0x1000..0x101C, then cpu_ack with cpu_rdata=0x0000_1004.
REQ-028 Repeat read 0x0000_1008 -> no mem_req, cpu_ack 2 cycles after cpu_req, cpu_rdata=0x0000_1008.
REQ-029 Write 0xDEAD_BEEF to 0x0000_1008 -> one mem write beat at 0x1008, cpu_ack; subsequent read 0x1008 hits returning 0xDEAD_BEEF.
REQ-030 Read 0x0040_1000 (same index, different tag) -> refill evicts; read 0x0000_1000 then misses and refills.
REQ-031 Assert rst after 3rd REFILL beat -> mem_req low next cycle, no cpu_ack; re-read same address performs full 8-beat refill.
REQ-032 With DCACHE_STATS_EN: sequence of REQ-027/028 -> miss_count=1, hit_count=1.
